// File: rtl/raster_pixel_writer_pkg.sv
// Shared definitions for the raster pixel writer: pixel entry layout,
// writer FSM encoding, clear defaults and a saturating counter helper.
package raster_defs;

    localparam int X_W     = 16;
    localparam int Y_W     = 16;
    localparam int DEPTH_W = 2;
    localparam int COLOR_W = 16;

    localparam logic [COLOR_W-1:0] DEFAULT_CLEAR_COLOR = 16'hF000;
    localparam logic [DEPTH_W-1:0] DEFAULT_CLEAR_DEPTH = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        CMP   = 3'd2,
        WR    = 3'd3,
        CLEAR = 3'd4
    } writer_state_t;

    typedef struct packed {
        logic [X_W-1:0]     x;
        logic [Y_W-1:0]     y;
        logic [DEPTH_W-1:0] depth;
        logic [COLOR_W-1:0] color;
    } pixel_entry_t;

    localparam int ENTRY_W = $bits(pixel_entry_t);

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/raster_pixel_writer_fifo.sv
// Synchronous FIFO for queued pixel entries; a push and a pop in the same
// cycle are both honoured, including when the FIFO is full.
module pixel_fifo #(
    parameter int WIDTH = 50,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;
    logic             full_s;
    logic             empty_s;

    assign full_s    = (count_r == CNT_MAX);
    assign empty_s   = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = push && (!full_s || pop);
    assign pop_ok_s  = pop && !empty_s;

    // Entry storage; contents need no reset because count_r qualifies them.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = full_s;
    assign empty   = empty_s;
    assign count   = count_r;

endmodule

// File: rtl/raster_pixel_writer.sv
// Pixel sink for the rasterizer: queues fragments, depth-tests them against an
// external depth buffer, writes survivors to the framebuffer and sweeps clears.
module raster_pixel_writer
    import raster_defs::*;
#(
    parameter int                 SCREEN_W    = 160,
    parameter int                 SCREEN_H    = 120,
    parameter int                 ADDR_W      = 15,
    parameter int                 FIFO_DEPTH  = 4,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = DEFAULT_CLEAR_COLOR,
    parameter logic [DEPTH_W-1:0] CLEAR_DEPTH = DEFAULT_CLEAR_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_sig_write_pixel,
    input  logic              in_sig_rasterize_done,
    input  logic              in_sig_clear,
    input  logic [15:0]       in_pixel_x,
    input  logic [15:0]       in_pixel_y,
    input  logic [1:0]        in_pixel_depth,
    input  logic [15:0]       in_pixel_color,
    output logic              out_sig_ready,
    output logic              out_sig_busy,
    output logic              out_sig_triangle_done,
    output logic [ADDR_W-1:0] out_mem_addr,
    output logic              out_depth_rd_en,
    input  logic [1:0]        in_depth_rd_data,
    output logic              out_depth_wr_en,
    output logic [1:0]        out_depth_wr_data,
    output logic              out_fb_wr_en,
    output logic [15:0]       out_fb_wr_data,
    output logic [15:0]       out_discard_count
);

    localparam int                CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] CLEAR_LAST = ADDR_W'(SCREEN_W * SCREEN_H - 1);

    writer_state_t state_r;
    writer_state_t state_next_s;

    pixel_entry_t      push_entry_s;
    pixel_entry_t      head_s;
    logic              push_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [CNT_W-1:0]  count_next_s;
    logic              head_oob_s;
    logic [ADDR_W-1:0] head_addr_s;

    logic [ADDR_W-1:0]  addr_r,           addr_next_s;
    logic               rd_en_r,          rd_en_next_s;
    logic               depth_wr_en_r,    depth_wr_en_next_s;
    logic [DEPTH_W-1:0] depth_wr_data_r,  depth_wr_data_next_s;
    logic               fb_wr_en_r,       fb_wr_en_next_s;
    logic [COLOR_W-1:0] fb_wr_data_r,     fb_wr_data_next_s;
    logic [DEPTH_W-1:0] frag_depth_r,     frag_depth_next_s;
    logic [COLOR_W-1:0] frag_color_r,     frag_color_next_s;
    logic [15:0]        discard_r,        discard_next_s;
    logic               clear_pending_r,  clear_pending_next_s;
    logic               done_pending_r,   done_pending_next_s;
    logic               ready_r,          ready_next_s;
    logic               busy_r,           busy_next_s;
    logic               tri_done_r;
    logic               clear_start_s;
    logic               clear_accept_s;
    logic               done_flag_s;
    logic               tri_fire_s;

    assign push_entry_s = {in_pixel_x, in_pixel_y, in_pixel_depth, in_pixel_color};
    assign push_s       = in_sig_write_pixel && ready_r && (!fifo_full_s || pop_s);

    pixel_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push_s),
        .wr_data (push_entry_s),
        .pop     (pop_s),
        .rd_data (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    assign head_oob_s  = (32'(head_s.x) >= 32'(SCREEN_W)) || (32'(head_s.y) >= 32'(SCREEN_H));
    assign head_addr_s = ADDR_W'(head_s.y) * ADDR_W'(SCREEN_W) + ADDR_W'(head_s.x);

    // Writer FSM: next state, pop request and next values of every output register.
    always_comb begin
        state_next_s         = state_r;
        pop_s                = 1'b0;
        clear_start_s        = 1'b0;
        addr_next_s          = addr_r;
        rd_en_next_s         = 1'b0;
        depth_wr_en_next_s   = 1'b0;
        depth_wr_data_next_s = depth_wr_data_r;
        fb_wr_en_next_s      = 1'b0;
        fb_wr_data_next_s    = fb_wr_data_r;
        frag_depth_next_s    = frag_depth_r;
        frag_color_next_s    = frag_color_r;
        discard_next_s       = discard_r;
        case (state_r)
            IDLE: begin
                if (clear_pending_r && fifo_empty_s) begin
                    state_next_s         = CLEAR;
                    clear_start_s        = 1'b1;
                    addr_next_s          = {ADDR_W{1'b0}};
                    depth_wr_en_next_s   = 1'b1;
                    depth_wr_data_next_s = CLEAR_DEPTH;
                    fb_wr_en_next_s      = 1'b1;
                    fb_wr_data_next_s    = CLEAR_COLOR;
                end else if (!fifo_empty_s) begin
                    pop_s = 1'b1;
                    // Off-screen fragments are dropped here without touching memory.
                    if (head_oob_s) begin
                        state_next_s   = IDLE;
                        discard_next_s = sat_inc16(discard_r);
                    end else begin
                        state_next_s      = RD;
                        addr_next_s       = head_addr_s;
                        rd_en_next_s      = 1'b1;
                        frag_depth_next_s = head_s.depth;
                        frag_color_next_s = head_s.color;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            RD: begin
                state_next_s = CMP;
            end
            CMP: begin
                if (frag_depth_r <= in_depth_rd_data) begin
                    state_next_s         = WR;
                    depth_wr_en_next_s   = 1'b1;
                    depth_wr_data_next_s = frag_depth_r;
                    fb_wr_en_next_s      = 1'b1;
                    fb_wr_data_next_s    = frag_color_r;
                end else begin
                    state_next_s   = IDLE;
                    discard_next_s = sat_inc16(discard_r);
                end
            end
            WR: begin
                state_next_s = IDLE;
            end
            CLEAR: begin
                if (addr_r == CLEAR_LAST) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s         = CLEAR;
                    addr_next_s          = addr_r + ADDR_W'(1);
                    depth_wr_en_next_s   = 1'b1;
                    depth_wr_data_next_s = CLEAR_DEPTH;
                    fb_wr_en_next_s      = 1'b1;
                    fb_wr_data_next_s    = CLEAR_COLOR;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // A clear pulse is only latched when no clear is pending or sweeping.
    assign clear_accept_s       = in_sig_clear && !clear_pending_r && (state_r != CLEAR);
    assign clear_pending_next_s = clear_pending_r ? !clear_start_s : clear_accept_s;

    assign count_next_s = fifo_count_s + CNT_W'(push_s) - CNT_W'(pop_s);

    // Done fires in the first cycle that shows an empty FIFO and an idle FSM.
    assign done_flag_s         = done_pending_r || in_sig_rasterize_done;
    assign tri_fire_s          = done_flag_s && (count_next_s == {CNT_W{1'b0}}) && (state_next_s == IDLE);
    assign done_pending_next_s = done_flag_s && !tri_fire_s;

    assign ready_next_s = (count_next_s != CNT_FULL) && !clear_pending_next_s && (state_next_s != CLEAR);
    assign busy_next_s  = (count_next_s != {CNT_W{1'b0}}) || (state_next_s != IDLE);

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath, flags and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_r          <= {ADDR_W{1'b0}};
            rd_en_r         <= 1'b0;
            depth_wr_en_r   <= 1'b0;
            depth_wr_data_r <= {DEPTH_W{1'b0}};
            fb_wr_en_r      <= 1'b0;
            fb_wr_data_r    <= {COLOR_W{1'b0}};
            frag_depth_r    <= {DEPTH_W{1'b0}};
            frag_color_r    <= {COLOR_W{1'b0}};
            discard_r       <= 16'd0;
            clear_pending_r <= 1'b0;
            done_pending_r  <= 1'b0;
            ready_r         <= 1'b1;
            busy_r          <= 1'b0;
            tri_done_r      <= 1'b0;
        end else begin
            addr_r          <= addr_next_s;
            rd_en_r         <= rd_en_next_s;
            depth_wr_en_r   <= depth_wr_en_next_s;
            depth_wr_data_r <= depth_wr_data_next_s;
            fb_wr_en_r      <= fb_wr_en_next_s;
            fb_wr_data_r    <= fb_wr_data_next_s;
            frag_depth_r    <= frag_depth_next_s;
            frag_color_r    <= frag_color_next_s;
            discard_r       <= discard_next_s;
            clear_pending_r <= clear_pending_next_s;
            done_pending_r  <= done_pending_next_s;
            ready_r         <= ready_next_s;
            busy_r          <= busy_next_s;
            tri_done_r      <= tri_fire_s;
        end
    end

    assign out_sig_ready         = ready_r;
    assign out_sig_busy          = busy_r;
    assign out_sig_triangle_done = tri_done_r;
    assign out_mem_addr          = addr_r;
    assign out_depth_rd_en       = rd_en_r;
    assign out_depth_wr_en       = depth_wr_en_r;
    assign out_depth_wr_data     = depth_wr_data_r;
    assign out_fb_wr_en          = fb_wr_en_r;
    assign out_fb_wr_data        = fb_wr_data_r;
    assign out_discard_count     = discard_r;

endmodule
